// File: rtl/pwm_audio_tx.sv
// Single-bit PWM audio transmitter: a single-entry pending buffer fed by valid/ready, one PWM frame
// of 2**WIDTH slots per sample, and the last sample repeated (with an underrun pulse) when starved.
module pwm_audio_tx #(
    parameter int unsigned WIDTH    = 5,
    parameter int unsigned PRESCALE = 4
) (
    input  logic             clk,
    input  logic             reset_central,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_valid,
    output logic             sample_ready,
    input  logic             enable,
    output logic             pwm_out,
    output logic             frame_start,
    output logic             underrun
);

    localparam int unsigned PRES_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRES_W-1:0] PRES_MAX = PRES_W'(PRESCALE - 1);
    localparam logic [WIDTH-1:0]  SLOT_MAX = {WIDTH{1'b1}};

    logic [PRES_W-1:0] pres_cnt_q, pres_cnt_d;
    logic [WIDTH-1:0]  slot_cnt_q, slot_cnt_d;
    logic [WIDTH-1:0]  active_q, active_d;
    logic [WIDTH-1:0]  pend_q, pend_d;
    logic              pend_full_q, pend_full_d;
    logic              pwm_out_q, pwm_out_d;
    logic              frame_start_q, frame_start_d;
    logic              underrun_q, underrun_d;

    logic tick;
    logic boundary;
    logic accept;

    assign tick         = enable && (pres_cnt_q == PRES_MAX);
    assign boundary     = tick && (slot_cnt_q == SLOT_MAX);
    assign accept       = sample_valid && !pend_full_q;
    assign sample_ready = !pend_full_q;

    assign pwm_out      = pwm_out_q;
    assign frame_start  = frame_start_q;
    assign underrun     = underrun_q;

    // Next-state: counters run only while enabled; buffer and handshake are always live.
    always_comb begin
        pres_cnt_d    = '0;
        slot_cnt_d    = '0;
        active_d      = active_q;
        pend_d        = pend_q;
        pend_full_d   = pend_full_q;
        pwm_out_d     = 1'b0;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;

        if (enable) begin
            pres_cnt_d = tick ? '0 : pres_cnt_q + PRES_W'(1);
            slot_cnt_d = tick ? slot_cnt_q + WIDTH'(1) : slot_cnt_q;
            pwm_out_d  = (slot_cnt_q < active_q);
        end

        // A load and an accept never coincide: accept requires the buffer to be empty.
        if (boundary) begin
            frame_start_d = 1'b1;
            if (pend_full_q) begin
                active_d    = pend_q;
                pend_full_d = 1'b0;
            end else begin
                underrun_d  = 1'b1;
            end
        end

        if (accept) begin
            pend_d      = sample_in;
            pend_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset_central) begin
        if (reset_central) begin
            pres_cnt_q    <= '0;
            slot_cnt_q    <= '0;
            active_q      <= '0;
            pend_q        <= '0;
            pend_full_q   <= 1'b0;
            pwm_out_q     <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            pres_cnt_q    <= pres_cnt_d;
            slot_cnt_q    <= slot_cnt_d;
            active_q      <= active_d;
            pend_q        <= pend_d;
            pend_full_q   <= pend_full_d;
            pwm_out_q     <= pwm_out_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
        end
    end

endmodule
